// File: rtl/mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Multi-cycle sequencer for the MIPS core. Each instruction is stepped
// through FETCH -> DECODE -> EXEC -> (MEM | WB) and then retires. The block
// owns the PC and the instruction/data memory request-acknowledge handshakes.
// It also gates the IR load, the ALU capture, the register-file write and the
// data-memory write, using the decoder's write_reg/write_mem/valid flags.
//
// Parameters:
//   PC_W         PC width; the PC wraps modulo 2**PC_W
//   RESET_PC     PC value after reset
//   ACK_TIMEOUT  maximum number of request cycles without an ack before a
//                fault is raised; 0 means wait forever
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   run               level: 1 = execute, 0 = stop at the next retire boundary
//   imem_req/ack      instruction fetch handshake (fetch address is pc)
//   pc                current instruction address
//   ir_we             instruction-register load pulse (same cycle as imem_ack)
//   dec_write_reg     decoder: the instruction writes the register file
//   dec_write_mem     decoder: the instruction writes data memory
//   dec_valid         decoder: alu_ctrl is a legal encoding
//   alu_en            ALU operand/result capture pulse
//   rf_we             register-file write strobe
//   dmem_req/ack      data-memory write handshake
//   busy              high in every state except IDLE and HALT
//   halted            high in HALT
//   err_code          0 none, 1 illegal instruction, 2 fetch timeout,
//                     3 data timeout
//
// Optional feature (macro PERF_CNT_EN):
//   Adds retired_cnt[31:0] (one count per retired instruction) and
//   stall_cnt[31:0] (one count per request cycle without an ack). Both clear
//   on reset and wrap at 2**32. With the macro undefined the ports and
//   counters are absent and the behaviour is otherwise identical.
// ----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              ACK_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    input  logic            imem_ack,
    output logic [PC_W-1:0] pc,
    output logic            ir_we,
    input  logic            dec_write_reg,
    input  logic            dec_write_mem,
    input  logic            dec_valid,
    output logic            alu_en,
    output logic            rf_we,
    output logic            dmem_req,
    input  logic            dmem_ack,
    output logic            busy,
    output logic            halted,
    output logic [1:0]      err_code
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]     retired_cnt,
    output logic [31:0]     stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_FETCH   = 2'd2;
    localparam logic [1:0] ERR_DATA    = 2'd3;

    // The wait counter only has to reach ACK_TIMEOUT-1.
    localparam int              CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             write_reg_q;
    logic             write_mem_q;
    logic             retire;
    logic             set_err;
    logic [1:0]       err_next;
    logic             waiting;
    logic             timeout_hit;

    // A "waiting" cycle is a request cycle in which the memory did not answer.
    // It drives both the timeout counter and the stall statistic.
    assign waiting     = ((state == S_FETCH) && !imem_ack) ||
                         ((state == S_MEM)   && !dmem_ack);
    assign timeout_hit = (ACK_TIMEOUT != 0) && (wait_cnt == CNT_LAST);

    // State register plus the registers that change with it: the PC advances
    // only on the edge that retires an instruction, the error code is written
    // once on the way into HALT, and the decoder's write flags are captured
    // in DECODE so EXEC steers on values taken while the IR was known stable.
    // The wait counter is zero whenever no request is pending, so it always
    // starts from zero on entry to FETCH or MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            err_code    <= 2'd0;
            wait_cnt    <= '0;
            write_reg_q <= 1'b0;
            write_mem_q <= 1'b0;
        end else begin
            state <= next_state;
            if (retire) begin
                pc <= pc + PC_W'(4);
            end
            if (set_err) begin
                err_code <= err_next;
            end
            wait_cnt <= waiting ? wait_cnt + CNT_W'(1) : '0;
            if (state == S_DECODE) begin
                write_reg_q <= dec_write_reg;
                write_mem_q <= dec_write_mem;
            end
        end
    end

    // Next-state logic. An ack arriving on the last allowed cycle is checked
    // before the timeout, so it wins. When both write flags are set the
    // instruction goes to MEM and never reaches WB. Every retire point shares
    // one exit: FETCH if run is still high, otherwise IDLE.
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        set_err    = 1'b0;
        err_next   = 2'd0;
        case (state)
            S_IDLE: begin
                if (run) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    next_state = S_DECODE;
                end else if (timeout_hit) begin
                    next_state = S_HALT;
                    set_err    = 1'b1;
                    err_next   = ERR_FETCH;
                end
            end
            S_DECODE: begin
                if (!dec_valid) begin
                    next_state = S_HALT;
                    set_err    = 1'b1;
                    err_next   = ERR_ILLEGAL;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (write_mem_q) begin
                    next_state = S_MEM;
                end else if (write_reg_q) begin
                    next_state = S_WB;
                end else begin
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    retire = 1'b1;
                end else if (timeout_hit) begin
                    next_state = S_HALT;
                    set_err    = 1'b1;
                    err_next   = ERR_DATA;
                end
            end
            S_WB: begin
                retire = 1'b1;
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
        if (retire) begin
            next_state = run ? S_FETCH : S_IDLE;
        end
    end

    // Strobes and status decode straight from the state register. The only
    // exception is ir_we, which follows imem_ack so the IR loads in the same
    // cycle the fetch data is valid. Because the state resets asynchronously,
    // a pending request drops as soon as rst_n falls.
    always_comb begin
        imem_req = (state == S_FETCH);
        ir_we    = (state == S_FETCH) && imem_ack;
        alu_en   = (state == S_EXEC);
        rf_we    = (state == S_WB);
        dmem_req = (state == S_MEM);
        busy     = (state != S_IDLE) && (state != S_HALT);
        halted   = (state == S_HALT);
    end

`ifdef PERF_CNT_EN
    // Performance counters. Both are free-running and wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= 32'd0;
            stall_cnt   <= 32'd0;
        end else begin
            if (retire) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
            if (waiting) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
